// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Pipelined RV32I instruction encoder (inverse of the immediate
//            generator). Decoded fields plus a sign-extended byte-offset
//            immediate are packed into a 32-bit instruction word according to
//            the ExtOP format code. The immediate is range-checked, and each
//            word is tagged with a sequential byte address for the
//            instruction-memory write port.
// Ports    : clk, rst (async, active-high), restart (sync address reload)
//            in_valid/in_ready       - input handshake for the decoded fields
//            ExtOP, opcode, rd, rs1, rs2, funct3, funct7, imm - fields
//            out_valid/out_ready     - output handshake
//            out_instr, out_addr, out_err - encoded word, its address, error
//            err_count               - saturating count of delivered errors
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int          ADDR_W    = 15,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        ExtOP,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0]        FMT_I      = 3'd0;
    localparam logic [2:0]        FMT_U      = 3'd1;
    localparam logic [2:0]        FMT_S      = 3'd2;
    localparam logic [2:0]        FMT_B      = 3'd3;
    localparam logic [2:0]        FMT_J      = 3'd4;
    localparam logic [2:0]        FMT_R      = 3'd5;
    localparam logic [31:0]       NOP_INSTR  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] ADDR_BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(4);
    localparam logic [7:0]        ERR_MAX    = 8'hFF;

    // ------------------------------------------------------------------
    // Stage 1: captured input fields
    // ------------------------------------------------------------------
    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  s1_fmt_q;
    logic [6:0]  s1_opcode_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [2:0]  s1_funct3_q;
    logic [6:0]  s1_funct7_q;
    logic [31:0] s1_imm_q;

    // ------------------------------------------------------------------
    // Stage 2: output word, address and error bookkeeping
    // ------------------------------------------------------------------
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic              out_err_q,   out_err_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [7:0]        err_cnt_q,   err_cnt_d;

    // Handshake terms
    logic in_accept;
    logic out_fire;
    logic s2_load;

    // Packing results (combinational from stage 1)
    logic [31:0] pack_instr;
    logic        pack_err;

    // Sign-consistency of the immediate's upper bits. A field of width N
    // can represent the value only when every bit from N-1 upward equals
    // the sign bit, i.e. the slice is all ones or all zeros.
    logic imm_fits_12;  // bits [31:11] uniform: I and S formats
    logic imm_fits_13;  // bits [31:12] uniform: B format
    logic imm_fits_21;  // bits [31:20] uniform: J format
    logic imm_low_zero; // bits [11:0] clear:   U format

    // ------------------------------------------------------------------
    // Handshake logic
    // ------------------------------------------------------------------
    // Stage 1 may take a new word when it is empty, or when its current
    // word will move into stage 2 on this edge (stage 2 empty or draining).
    // in_ready is forced low while reset is asserted so no word is counted
    // as accepted by the producer during reset.
    assign in_ready  = !rst && (!s1_valid_q || !out_valid_q || out_ready);
    assign in_accept = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign s2_load   = s1_valid_q && (!out_valid_q || out_ready);

    // ------------------------------------------------------------------
    // Immediate range checks
    // ------------------------------------------------------------------
    assign imm_fits_12  = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
    assign imm_fits_13  = (&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]);
    assign imm_fits_21  = (&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]);
    assign imm_low_zero = !(|s1_imm_q[11:0]);

    // ------------------------------------------------------------------
    // Instruction packing
    // ------------------------------------------------------------------
    // Out-of-range immediates still produce the truncated packed bits so the
    // consumer sees what would have been written; only out_err flags them.
    always_comb begin
        pack_instr = NOP_INSTR;
        pack_err   = 1'b1;
        case (s1_fmt_q)
            FMT_I: begin
                pack_instr = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q,
                              s1_rd_q, s1_opcode_q};
                pack_err   = !imm_fits_12;
            end
            FMT_U: begin
                pack_instr = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
                pack_err   = !imm_low_zero;
            end
            FMT_S: begin
                pack_instr = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q,
                              s1_funct3_q, s1_imm_q[4:0], s1_opcode_q};
                pack_err   = !imm_fits_12;
            end
            FMT_B: begin
                // Branch offsets are halfword aligned; bit 0 is not encoded.
                pack_instr = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q,
                              s1_rs1_q, s1_funct3_q, s1_imm_q[4:1],
                              s1_imm_q[11], s1_opcode_q};
                pack_err   = !imm_fits_13 || s1_imm_q[0];
            end
            FMT_J: begin
                pack_instr = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                              s1_imm_q[19:12], s1_rd_q, s1_opcode_q};
                pack_err   = !imm_fits_21 || s1_imm_q[0];
            end
            FMT_R: begin
                pack_instr = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q,
                              s1_rd_q, s1_opcode_q};
                pack_err   = 1'b0;
            end
            default: begin
                // Illegal format: emit a harmless NOP and flag it.
                pack_instr = NOP_INSTR;
                pack_err   = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Stage 1 occupancy: a new accept refills it even when the current
        // word leaves in the same edge.
        s1_valid_d = s1_valid_q;
        if (in_accept) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        // Stage 2 holds its contents stable until it is handshaken.
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            out_instr_d = pack_instr;
            out_err_d   = pack_err;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        // Address counter labels the word in stage 2. It wraps naturally
        // at 2^ADDR_W; restart wins over a same-cycle handshake, and the
        // word handshaken in that cycle has already used the old address.
        addr_d = addr_q;
        if (restart) begin
            addr_d = ADDR_BASE;
        end else if (out_fire) begin
            addr_d = addr_q + ADDR_STEP;
        end

        // Error counter counts delivered bad words and saturates.
        err_cnt_d = err_cnt_q;
        if (out_fire && out_err_q && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
    end

    // Payload fields need no reset: they are qualified by s1_valid_q.
    always_ff @(posedge clk) begin
        if (in_accept) begin
            s1_fmt_q    <= ExtOP;
            s1_opcode_q <= opcode;
            s1_rd_q     <= rd;
            s1_rs1_q    <= rs1;
            s1_rs2_q    <= rs2;
            s1_funct3_q <= funct3;
            s1_funct7_q <= funct7;
            s1_imm_q    <= imm;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_err_q   <= 1'b0;
            addr_q      <= ADDR_BASE;
            err_cnt_q   <= 8'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
            addr_q      <= addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign out_addr  = addr_q;
    assign err_count = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Self-checking bench for instr_encoder. A behavioural model
//            encodes fields and judges immediate ranges with plain signed
//            arithmetic; a scoreboard queue tracks words in flight. A second
//            instance with a 4-bit address counter shares the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    typedef struct {
        logic [2:0]  ext;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fields_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [2:0]  ext;
        logic [31:0] imm;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [14:0] addr;
        logic [3:0]  addr2;
        logic        err;
        int          cyc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  ExtOP = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_instr;
    logic [14:0] out_addr;
    logic [7:0]  err_count;
    logic        in_ready2, out_valid2, out_err2;
    logic [31:0] out_instr2;
    logic [3:0]  out_addr2;
    logic [7:0]  err_count2;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    fields_t in_q[$];
    exp_t    exp_q[$];
    obs_t    obs[$];
    int      exp_addr;
    int      exp_addr2;
    int      exp_err;
    int      n_out;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_encoder #(.ADDR_W(15), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .ExtOP(ExtOP), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .out_err(out_err), .err_count(err_count)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut_w4 (
        .clk(clk), .rst(rst), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready2),
        .ExtOP(ExtOP), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_instr(out_instr2), .out_addr(out_addr2),
        .out_err(out_err2), .err_count(err_count2)
    );

    // ---------------- reference model ----------------
    function automatic exp_t model(input fields_t f);
        exp_t        e;
        logic [31:0] i;
        int          s;
        i = f.imm;
        s = $signed(f.imm);
        e.ext = f.ext;
        e.imm = f.imm;
        case (f.ext)
            3'd0: begin
                e.instr = {i[11:0], f.rs1, f.f3, f.rd, f.opc};
                e.err   = !(s >= -2048 && s <= 2047);
            end
            3'd1: begin
                e.instr = {i[31:12], f.rd, f.opc};
                e.err   = (f.imm % 4096) != 0;
            end
            3'd2: begin
                e.instr = {i[11:5], f.rs2, f.rs1, f.f3, i[4:0], f.opc};
                e.err   = !(s >= -2048 && s <= 2047);
            end
            3'd3: begin
                e.instr = {i[12], i[10:5], f.rs2, f.rs1, f.f3, i[4:1], i[11], f.opc};
                e.err   = !(s >= -4096 && s <= 4095 && (s % 2) == 0);
            end
            3'd4: begin
                e.instr = {i[20], i[10:1], i[11], i[19:12], f.rd, f.opc};
                e.err   = !(s >= -1048576 && s <= 1048575 && (s % 2) == 0);
            end
            3'd5: begin
                e.instr = {f.f7, f.rs2, f.rs1, f.f3, f.rd, f.opc};
                e.err   = 1'b0;
            end
            default: begin
                e.instr = 32'h0000_0013;
                e.err   = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Decoder-side immediate generator used for the round trip.
    function automatic logic [31:0] immgen(input logic [31:0] x, input logic [2:0] ext);
        case (ext)
            3'd0:    return {{20{x[31]}}, x[31:20]};
            3'd1:    return {x[31:12], 12'b0};
            3'd2:    return {{20{x[31]}}, x[31:25], x[11:7]};
            3'd3:    return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            3'd4:    return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
            default: return 32'b0;
        endcase
    endfunction

    function automatic fields_t mk(input logic [2:0] ext, input logic [6:0] opc,
                                   input logic [4:0] r_d, input logic [4:0] r_s1,
                                   input logic [4:0] r_s2, input logic [2:0] f3,
                                   input logic [31:0] iv);
        fields_t f;
        f.ext = ext; f.opc = opc; f.rd = r_d; f.rs1 = r_s1; f.rs2 = r_s2;
        f.f3 = f3; f.f7 = 7'($urandom); f.imm = iv;
        return f;
    endfunction

    function automatic fields_t rand_legal();
        fields_t f;
        int      v;
        f = mk(3'($urandom_range(5)), 7'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 3'($urandom), $urandom);
        case (f.ext)
            3'd0, 3'd2: begin v = int'($urandom_range(4095)) - 2048; f.imm = v; end
            3'd1:       f.imm = $urandom & 32'hFFFF_F000;
            3'd3: begin v = int'($urandom_range(8191)) - 4096; f.imm = v & 32'hFFFF_FFFE; end
            3'd4: begin v = int'($urandom_range(2097151)) - 1048576; f.imm = v & 32'hFFFF_FFFE; end
            default: f.imm = $urandom;
        endcase
        return f;
    endfunction

    function automatic fields_t rand_error();
        fields_t f;
        int      v;
        f = rand_legal();
        case ($urandom_range(4))
            0: begin f.ext = 3'd0; v = 2048 + int'($urandom_range(1 << 20)); f.imm = v; end
            1: begin f.ext = 3'd1; f.imm = $urandom | 32'h1; end
            2: begin f.ext = 3'd3; v = int'($urandom_range(8191)) - 4096; f.imm = v | 1; end
            3: begin f.ext = 3'd4; f.imm = 32'h0010_0000 | ($urandom & 32'h000F_FFFE); end
            default: f.ext = 3'(6 + $urandom_range(1));
        endcase
        return f;
    endfunction

    task automatic drive(input fields_t f);
        ExtOP = f.ext; opcode = f.opc; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2;
        funct3 = f.f3; funct7 = f.f7; imm = f.imm;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; restart = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_q.delete(); exp_q.delete(); obs.delete();
        exp_addr = 0; exp_addr2 = 0; exp_err = 0; n_out = 0;
    endtask

    // Cycle engine: drives queued inputs with random flow control and
    // checks every sampled cycle against the scoreboard. Called and
    // returns at posedge+1.
    task automatic run_engine(input int p_in, input int p_ready, input int max_cyc,
                              input int restart_at, input bit must_drain);
        int   n;
        bit   hs_in, hs_out, hd_err, exp_rdy;
        exp_t hd;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < max_cyc) begin
            if (in_q.size() > 0 && int'($urandom_range(99)) < p_in) begin
                drive(in_q[0]); in_valid = 1'b1;
            end else begin
                drive(rand_legal()); in_valid = 1'b0;
            end
            out_ready = int'($urandom_range(99)) < p_ready;
            restart = (restart_at >= 0) && out_valid && out_ready && (n_out == restart_at);
            @(negedge clk);
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            hd_err = 1'b0;
            exp_rdy = (exp_q.size() < 2) || out_ready;
            total++;
            if (in_ready !== exp_rdy || in_ready2 !== exp_rdy) begin
                bad++; $display("FAIL in_ready got=%b/%b exp=%b", in_ready, in_ready2, exp_rdy);
            end
            total++;
            if (err_count !== 8'(exp_err) || err_count2 !== 8'(exp_err)) begin
                bad++; $display("FAIL err_count got=%0d exp=%0d", err_count, exp_err);
            end
            total++;
            if (out_valid2 !== out_valid) begin
                bad++; $display("FAIL out_valid_w4 got=%b exp=%b", out_valid2, out_valid);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_word got=%h exp=none", out_instr);
                end else begin
                    hd = exp_q[0];
                    total++;
                    if (out_instr !== hd.instr || out_instr2 !== hd.instr) begin
                        bad++; $display("FAIL out_instr got=%h exp=%h", out_instr, hd.instr);
                    end
                    total++;
                    if (out_err !== hd.err || out_err2 !== hd.err) begin
                        bad++; $display("FAIL out_err got=%b exp=%b", out_err, hd.err);
                    end
                    total++;
                    if (out_addr !== 15'(exp_addr) || out_addr2 !== 4'(exp_addr2)) begin
                        bad++; $display("FAIL out_addr got=%h/%h exp=%h/%h",
                                        out_addr, out_addr2, 15'(exp_addr), 4'(exp_addr2));
                    end
                    if (out_ready) begin
                        hd = exp_q.pop_front();
                        hd_err = hd.err;
                        if (!hd.err && hd.ext < 3'd5) begin
                            total++;
                            if (immgen(out_instr, hd.ext) !== hd.imm) begin
                                bad++; $display("FAIL roundtrip got=%h exp=%h ext=%0d",
                                                immgen(out_instr, hd.ext), hd.imm, hd.ext);
                            end
                        end
                        obs.push_back('{out_instr, out_addr, out_addr2, out_err, cyc});
                    end
                end
            end
            if (hs_in) exp_q.push_back(model(in_q.pop_front()));
            @(posedge clk); #1;
            if (restart) begin
                exp_addr = 0; exp_addr2 = 0;
            end else if (hs_out) begin
                exp_addr  = (exp_addr + 4) % 32768;
                exp_addr2 = (exp_addr2 + 4) % 16;
            end
            if (hs_out) n_out++;
            if (hs_out && hd_err && exp_err < 255) exp_err++;
            n++;
        end
        in_valid = 1'b0; out_ready = 1'b0; restart = 1'b0;
        if (must_drain && (in_q.size() > 0 || exp_q.size() > 0)) begin
            total++; bad++;
            $display("FAIL drain_timeout got=%0d/%0d pending exp=0", in_q.size(), exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_out_instr got=%h exp=0", out_instr); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err got=%b exp=0", out_err); end
        total++; if (out_addr !== 15'h0 || out_addr2 !== 4'h0) begin bad++; $display("FAIL rst_out_addr got=%h exp=0", out_addr); end
        total++; if (err_count !== 8'h0) begin bad++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
        do_reset();
    endtask

    task automatic test_single_i();
        do_reset();
        drive(mk(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF));
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_accept got=%b exp=1", in_ready); end
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_latency got=%b exp=1", out_valid); end
        total++; if (out_instr !== 32'hFFF0_0093) begin bad++; $display("FAIL single_instr got=%h exp=fff00093", out_instr); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", out_err); end
        total++; if (out_addr !== 15'h0) begin bad++; $display("FAIL single_addr got=%h exp=0", out_addr); end
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] gold [4];
        gold = '{32'h1234_52B7, 32'h0020_A423, 32'hFE00_0EE3, 32'h0080_00EF};
        do_reset();
        in_q.push_back(mk(3'd1, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000));
        in_q.push_back(mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8));
        in_q.push_back(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC));
        in_q.push_back(mk(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8));
        run_engine(100, 100, 40, -1, 1);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs.size() <= k) begin
                bad++; $display("FAIL b2b_missing got=%0d words exp=4", obs.size());
            end else if (obs[k].instr !== gold[k] || obs[k].addr !== 15'(4 * k) ||
                         obs[k].cyc != obs[0].cyc + k) begin
                bad++; $display("FAIL b2b_word%0d got=%h@%h cyc+%0d exp=%h@%h cyc+%0d", k,
                                obs[k].instr, obs[k].addr, obs[k].cyc - obs[0].cyc,
                                gold[k], 15'(4 * k), k);
            end
        end
    endtask

    task automatic test_errors();
        do_reset();
        in_q.push_back(mk(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'd2048));
        in_q.push_back(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3));
        in_q.push_back(mk(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 32'd0));
        run_engine(100, 100, 40, -1, 1);
        total++;
        if (obs.size() != 3 || obs[0].err !== 1'b1 || obs[1].err !== 1'b1 || obs[2].err !== 1'b1) begin
            bad++; $display("FAIL err_flags got=%0d words exp=3 flagged", obs.size());
        end
        total++;
        if (obs.size() < 3 || obs[2].instr !== 32'h0000_0013) begin
            bad++; $display("FAIL err_nop got=%h exp=00000013", obs.size() < 3 ? 32'hx : obs[2].instr);
        end
        @(negedge clk);
        total++; if (err_count !== 8'd3) begin bad++; $display("FAIL err_count3 got=%0d exp=3", err_count); end
        @(posedge clk); #1;
        for (int k = 0; k < 300; k++) in_q.push_back(rand_error());
        run_engine(80, 80, 5000, -1, 1);
        @(negedge clk);
        total++; if (err_count !== 8'd255) begin bad++; $display("FAIL err_saturate got=%0d exp=255", err_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int accepted;
        do_reset();
        for (int k = 0; k < 3; k++) in_q.push_back(rand_legal());
        run_engine(100, 0, 5, -1, 0);
        accepted = 3 - in_q.size();
        total++; if (accepted != 2) begin bad++; $display("FAIL bp_accepts got=%0d exp=2", accepted); end
        in_valid = 1'b1; drive(in_q[0]);
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1; in_valid = 1'b0;
        run_engine(100, 100, 40, -1, 1);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs.size() <= k || obs[k].addr !== 15'(4 * k)) begin
                bad++; $display("FAIL bp_addr%0d got=%0d words exp=addr %0d", k, obs.size(), 4 * k);
            end
        end
    endtask

    task automatic test_wrap_restart();
        int a2 [5];
        a2 = '{0, 4, 8, 12, 0};
        do_reset();
        for (int k = 0; k < 5; k++) in_q.push_back(mk(3'd5, 7'h33, 5'(k), 5'd1, 5'd2, 3'd0, 32'd0));
        run_engine(100, 100, 40, -1, 1);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (obs.size() <= k || obs[k].addr2 !== 4'(a2[k])) begin
                bad++; $display("FAIL wrap_addr%0d got=%0d words exp=addr %0d", k, obs.size(), a2[k]);
            end
        end
        do_reset();
        in_q.push_back(mk(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0));
        for (int k = 0; k < 4; k++) in_q.push_back(rand_legal());
        run_engine(100, 100, 40, 2, 1);
        total++;
        if (obs.size() < 4 || obs[2].addr !== 15'd8 || obs[3].addr !== 15'd0) begin
            bad++; $display("FAIL restart_addr got=%0d words exp=8 then 0", obs.size());
        end
        @(negedge clk);
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL restart_keeps_err got=%0d exp=1", err_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_roundtrip();
        do_reset();
        for (int k = 0; k < 1000; k++) in_q.push_back(rand_legal());
        run_engine(70, 70, 10000, -1, 1);
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int k = 0; k < 6; k++) in_q.push_back(rand_legal());
        run_engine(100, 100, 4, -1, 0);
        run_engine(100, 0, 3, -1, 0);
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", in_ready); end
        total++; if (out_addr !== 15'd0) begin bad++; $display("FAIL midrst_addr got=%h exp=0", out_addr); end
        @(posedge clk); #1; rst = 1'b0;
        in_q.delete(); exp_q.delete(); obs.delete();
        exp_addr = 0; exp_addr2 = 0; exp_err = 0; n_out = 0;
        in_q.push_back(rand_legal());
        run_engine(100, 100, 20, -1, 1);
        total++;
        if (obs.size() != 1 || obs[0].addr !== 15'd0) begin
            bad++; $display("FAIL midrst_next got=%0d words exp=1 word at 0", obs.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_back_to_back();
        test_errors();
        test_backpressure();
        test_wrap_restart();
        test_roundtrip();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
